// File: rtl/parity_fifo.sv
// parity_fifo: parity-checked FIFO between the upstream filter stage and a
// ready/valid consumer. Words whose parity bit disagrees with the data are
// dropped and counted. Good words that arrive while the FIFO is full, with no
// pop that cycle, are dropped and latch a sticky overflow flag.
module parity_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     in_parity,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               err_count,
  output logic                     overflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic word_good;
  logic word_bad;
  logic pop;
  logic push;
  logic drop;

  // Classify the incoming word and decide whether this cycle pushes, pops or drops.
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a word.
  always_comb begin
    word_good = (in_parity == ^in_data);
    word_bad  = in_valid & ~word_good;
    pop       = out_valid & out_ready;
    push      = in_valid & word_good & ((level < FULL_LEVEL) | pop);
    drop      = in_valid & word_good & ~push;
  end

  // The head is visible whenever anything is stored; idle output reads as zero.
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage array carries no reset; stale entries are never visible because
  // out_data is gated by the level count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and entry count; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        level <= level + LEVEL_ONE;
      end else if (pop && !push) begin
        level <= level - LEVEL_ONE;
      end
    end
  end

  // Saturating parity-error counter; a clear still counts a bad word arriving that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= {7'd0, word_bad};
    end else if (word_bad && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  // Sticky overflow flag; a clear still records a drop happening that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (err_clr) begin
      overflow <= drop;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_fifo.sv
// tb_parity_fifo: directed stimulus for parity_fifo with a scoreboard queue.
// Stimulus pushes each word it expects the FIFO to accept; an independent
// monitor pops and compares whenever a pop is observed.
module tb_parity_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_parity = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       level;
  logic [7:0]       err_count;
  logic             overflow;
  logic             err_clr = 1'b0;

  logic [WIDTH-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  parity_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_parity (in_parity),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .err_count (err_count),
    .overflow  (overflow),
    .err_clr   (err_clr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d, input logic p,
                                input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    in_parity = p;
    out_ready = r;
    err_clr   = c;
    @(posedge clk);
    #1;
  endtask

  // Monitor: on the falling edge, any cycle with out_valid and out_ready is a pop
  // at the coming edge, so the head word must match the scoreboard front.
  always @(negedge clk) begin
    if (rst) begin
      if (!out_valid) begin
        check_output("idle_data_zero", 32'(out_data), 32'h0);
      end
      if (out_valid && prev_valid && !prev_ready) begin
        check_output("head_stable", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no word", out_data);
        end else begin
          check_output("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_valid <= out_valid;
    prev_ready <= out_ready;
    prev_data  <= out_data;
  end

  initial begin
    logic [WIDTH-1:0] d;

    // Reset held with a valid word on the input: nothing may be stored.
    rst = 1'b0;
    repeat (3) apply_stimulus(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    check_output("rst_out_valid", 32'(out_valid), 32'h0);
    check_output("rst_out_data", 32'(out_data), 32'h0);
    check_output("rst_level", 32'(level), 32'h0);
    check_output("rst_err_count", 32'(err_count), 32'h0);
    check_output("rst_overflow", 32'(overflow), 32'h0);
    in_valid = 1'b0;
    rst = 1'b1;

    // Single push, visible on the following cycle, then popped.
    exp_q.push_back(16'h000C);
    apply_stimulus(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check_output("single_valid", 32'(out_valid), 32'h1);
    check_output("single_data", 32'(out_data), 32'h000C);
    check_output("single_level", 32'(level), 32'h1);
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    check_output("single_drain_level", 32'(level), 32'h0);
    check_output("single_drain_data", 32'(out_data), 32'h0);

    // Parity error: 0x0003 has XOR 0, parity bit 1 is wrong.
    apply_stimulus(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    check_output("bad_level", 32'(level), 32'h0);
    check_output("bad_err_count", 32'(err_count), 32'h1);
    for (int k = 0; k < 300; k++) begin
      d = 16'(k * 37 + 5);
      apply_stimulus(1'b1, d, ~(^d), 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    check_output("err_saturate", 32'(err_count), 32'd255);
    check_output("bad_flood_level", 32'(level), 32'h0);
    apply_stimulus(1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);
    check_output("clr_with_bad", 32'(err_count), 32'h1);
    apply_stimulus(1'b0, 16'h0003, 1'b1, 1'b0, 1'b1);
    check_output("err_clr", 32'(err_count), 32'h0);
    apply_stimulus(1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    check_output("invalid_ignored", 32'(err_count), 32'h0);

    // Overflow: nine good words into eight slots; word 9 is dropped.
    for (int i = 1; i <= 9; i++) begin
      d = 16'(i);
      if (i <= 8) exp_q.push_back(d);
      apply_stimulus(1'b1, d, ^d, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    check_output("ovf_level", 32'(level), 32'd8);
    check_output("ovf_flag", 32'(overflow), 32'h1);
    check_output("ovf_head", 32'(out_data), 32'h1);
    check_output("ovf_err_untouched", 32'(err_count), 32'h0);
    repeat (8) apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    check_output("ovf_drained_level", 32'(level), 32'h0);
    check_output("ovf_drained_queue", 32'(exp_q.size()), 32'h0);
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    err_clr = 1'b0;
    check_output("ovf_cleared", 32'(overflow), 32'h0);

    // Full FIFO with simultaneous push and pop: no drop, pointers wrap.
    for (int i = 1; i <= 8; i++) begin
      d = 16'(i);
      exp_q.push_back(d);
      apply_stimulus(1'b1, d, ^d, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    check_output("full_level", 32'(level), 32'd8);
    exp_q.push_back(16'h0009);
    apply_stimulus(1'b1, 16'h0009, 1'b0, 1'b1, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("pushpop_level", 32'(level), 32'd8);
    check_output("pushpop_no_ovf", 32'(overflow), 32'h0);
    check_output("pushpop_head", 32'(out_data), 32'h2);
    repeat (8) apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    check_output("wrap_drained_level", 32'(level), 32'h0);
    check_output("wrap_drained_queue", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset with five words stored, pulsed between edges.
    for (int i = 0; i < 5; i++) begin
      d = 16'(16'h0010 + i);
      exp_q.push_back(d);
      apply_stimulus(1'b1, d, ^d, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    check_output("pre_reset_level", 32'(level), 32'd5);
    rst = 1'b0;
    exp_q.delete();
    #2;
    check_output("async_rst_valid", 32'(out_valid), 32'h0);
    check_output("async_rst_level", 32'(level), 32'h0);
    check_output("async_rst_data", 32'(out_data), 32'h0);
    rst = 1'b1;
    exp_q.push_back(16'h0005);
    apply_stimulus(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check_output("post_rst_valid", 32'(out_valid), 32'h1);
    check_output("post_rst_data", 32'(out_data), 32'h0005);
    check_output("post_rst_level", 32'(level), 32'h1);
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_output("final_level", 32'(level), 32'h0);
    check_output("final_queue", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_fifo.md
PARITY_FIFO -- requirements
Module: parity_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: width of data words.
REQ-002 The block SHALL have parameter DEPTH, default 8: FIFO entries, a power of 2 and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: sample from the upstream filter stage.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data/in_parity valid this cycle; there is no upstream backpressure.
REQ-007 The block SHALL have port in_parity, input, 1 bit: parity of in_data.
REQ-008 The block SHALL have port out_data, output, WIDTH bits: FIFO head word.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word this cycle.
REQ-011 The block SHALL have port level, output, clog2(DEPTH)+1 bits: current entry count.
REQ-012 The block SHALL have port err_count, output, 8 bits: number of words dropped for parity error.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a good word is dropped because the FIFO is full.
REQ-014 The block SHALL have port err_clr, input, 1 bit: synchronous clear of err_count and overflow.

Function
REQ-015 Parity check: a word SHALL be good when in_parity equals the XOR-reduction of in_data (0x000C with parity 0 is good; 0x0003 with parity 1 is bad).
REQ-016 Pop: a pop SHALL occur when out_valid and out_ready are both 1.
REQ-017 Push: a push SHALL occur when in_valid is 1, the word is good, and either level is below DEPTH or a pop occurs in the same cycle.
REQ-018 Storage and pointers:
- The write pointer and the read pointer SHALL each advance by 1 per push or pop respectively.
- Both pointers SHALL wrap from DEPTH-1 to 0.
- Words SHALL leave the FIFO in arrival order.
REQ-019 level SHALL be updated every cycle:
- +1 on push only.
- -1 on pop only.
- Unchanged on push and pop together, or on neither.
- level SHALL never exceed DEPTH and never go below 0.
REQ-020 Output validity:
- out_valid SHALL be 1 exactly when level is nonzero.
- out_data SHALL equal the head entry when out_valid is 1, and 0 when out_valid is 0.
REQ-021 Latency: a word pushed into an empty FIFO SHALL appear on out_data/out_valid on the cycle after the push edge; there is no same-cycle fall-through.
REQ-022 While out_valid is 1 and out_ready is 0, out_data SHALL hold stable.
REQ-023 Push and pop in the same cycle on an empty FIFO SHALL NOT occur, since out_valid is 0; the push proceeds normally.
REQ-024 A bad word with in_valid 1 SHALL NOT be stored.
REQ-025 err_count SHALL increment by 1 per bad word and saturate at 255.
REQ-026 A good word that is not pushed because the FIFO is full with no pop SHALL be dropped, and overflow SHALL be set to 1.
REQ-027 err_clr:
- err_clr 1 SHALL load err_count with 1 if a bad word arrives that cycle, else 0.
- err_clr 1 SHALL load overflow with 1 if a drop occurs that cycle, else 0.
- err_clr SHALL NOT affect FIFO contents or level.
REQ-028 When in_valid is 0, in_data and in_parity SHALL be ignored and SHALL have no effect on err_count.

Reset
REQ-029 While rst is 0, the block SHALL asynchronously drive:
- level = 0, out_valid = 0, out_data = 0;
- err_count = 0, overflow = 0;
- both pointers to 0.
REQ-030 Assertion of rst mid-operation SHALL discard all stored words immediately, without waiting for a clock edge.
REQ-031 On the first rising edge after rst returns to 1, the block SHALL accept input normally; memory contents need no reset.

Verification
REQ-032 The bench SHALL cover reset: hold rst = 0 with in_valid = 1 -> out_valid = 0, out_data = 0, level = 0, err_count = 0, overflow = 0.
REQ-033 The bench SHALL cover a single push: in_data = 0x000C, in_parity = 0, in_valid = 1 for one cycle, out_ready = 0 -> next cycle out_valid = 1, out_data = 0x000C, level = 1; then out_ready = 1 for one cycle -> level = 0, out_data = 0.
REQ-034 The bench SHALL cover a parity error: in_data = 0x0003, in_parity = 1, one cycle -> level unchanged, err_count = 1; then 300 bad words -> err_count = 255; then err_clr = 1 for one cycle -> err_count = 0.
REQ-035 The bench SHALL cover overflow: out_ready = 0, push 1..9 with correct parity -> level = 8, overflow = 1; then drain -> out_data sequence is 1..8 and word 9 is never output.
REQ-036 The bench SHALL cover simultaneous push and pop when full: FIFO holds 1..8, push 9 with out_ready = 1 -> level stays 8, overflow stays 0; full drain yields 2..9 (pointer wrap verified).
REQ-037 The bench SHALL cover reset mid-operation: with level = 5, pulse rst = 0 between clock edges -> out_valid = 0 and level = 0 immediately; after release, push 0x0005 (parity 0) -> out_data = 0x0005 next cycle.
